pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register that replaces the fixed-field, always-loading stage registers between CPU stages (EX/MEM, MEM/WB).
- Adds a valid/ready handshake for stalls, synchronous flush, control-field squashing on bubbles, and an optional 2-entry skid buffer so upstream ready is registered.
- Payload is split into a control bus (e.g. regwrite, memtoreg, jumplink) and a data bus (e.g. aluout, rd, writereg, pcplus4), concatenated by the instantiating stage.

Parameters:
- DATA_W, 32, width of data payload (bits)
- CTRL_W, 4, width of control payload; forced to zero whenever out_valid=0
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control fields
- in_data  in  DATA_W  upstream data fields
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control fields, zero when out_valid=0
- out_data  out  DATA_W  data fields
- count  out  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both sampled at posedge clk.
- Reset, when rst=1 at posedge:
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, count=0.
  - in_ready=1 on the cycle after reset.
  - Skid entry cleared.
  - rst has priority over flush and all transfers.
- Flush, when flush=1 at posedge (rst=0):
  - All entries discarded; count=0; out_valid=0.
  - An in_fire in the same cycle is dropped.
  - out_data keeps its old value; out_ctrl reads 0.
- SKID_EN=1 state machine (state == count):
  - EMPTY:
    - in_fire -> ONE (main <= in).
  - ONE:
    - in_fire & out_fire -> ONE (main <= in).
    - in_fire & ~out_fire -> FULL (skid <= in).
    - ~in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL:
    - in_ready=0, so no in_fire is possible.
    - out_fire -> ONE (main <= skid).
    - Otherwise hold.
  - in_ready is a register equal to (next state != FULL); it has no combinational path from out_ready.
- SKID_EN=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - in_fire loads main.
  - out_fire without in_fire -> EMPTY.
- Latency and throughput:
  - Latency is exactly 1 cycle from in_fire to out_valid when empty.
  - Sustained throughput is 1 entry/cycle with out_ready held high, in both modes.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush or rst.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}, so a bubble can never assert regwrite.
- out_data holds its last value across bubbles; it is only loaded on a transfer into main.
- Downstream stall (out_ready=0) with out_valid=1: out_ctrl and out_data remain stable until out_fire.
- in_valid=0 never changes state; in_ctrl and in_data are ignored when in_fire=0.

Decomposition:
- Shared package cpu_pipe_pkg: width constants (XLEN=32, REGADDR_W=5), control-field bit indices (CTL_REGWRITE, CTL_MEMTOREG, CTL_JUMPLINK), and the count encoding (CNT_EMPTY=0, CNT_ONE=1, CNT_FULL=2).
- No sub-module is needed: the main and skid registers plus the FSM fit in one module.
- The MEM/WB instance is pipe_skid_reg with CTRL_W=3 and DATA_W=32+32+5+32=101.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1, in_ctrl=4'hF.
  - Required: out_valid=0, out_ctrl=0, out_data=0, count=0; in_ready=1 on the first cycle after rst=0.
- Streaming:
  - Stimulus: out_ready=1; push data 1,2,3,4 on consecutive cycles, ctrl=4'b0101.
  - Required: outputs 1,2,3,4 on the following consecutive cycles, each with ctrl=4'b0101; count never exceeds 1.
- Stall and skid (SKID_EN=1):
  - Stimulus: push A=32'hAAAA_0001 and B=32'hBBBB_0002 while out_ready=0; release out_ready after 3 cycles.
  - Required: count=2 and in_ready=0 during the stall; out_data=A stable throughout; then A, then B, then count=0.
- Flush:
  - Stimulus: in the FULL state, assert flush together with in_valid carrying C.
  - Required: next cycle count=0, out_valid=0, out_ctrl=0; C never appears on the output.
- Bubble squash:
  - Stimulus: push ctrl=4'b1111, then drive in_valid=0 with out_ready=1.
  - Required: out_ctrl=0 on the bubble cycle while out_data keeps the last payload.
- Mode SKID_EN=0:
  - Stimulus: out_ready toggles 1,0,1.
  - Required: in_ready mirrors (out_ready | ~out_valid) in the same cycle; count never exceeds 1; FIFO order preserved.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: payload widths,
// control-field bit positions and the occupancy encoding used by pipe_skid_reg.
package cpu_pipe_pkg;

    localparam int XLEN      = 32;
    localparam int REGADDR_W = 5;

    localparam int CTL_REGWRITE = 0;
    localparam int CTL_MEMTOREG = 1;
    localparam int CTL_JUMPLINK = 2;

    // MEM/WB stage: {aluout, readdata, writereg, pcplus4} and three control bits
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = XLEN + XLEN + REGADDR_W + XLEN;

    // Occupancy of a stage register; the FSM state doubles as the count output
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

    function automatic logic cnt_is_full(input cnt_e c);
        return c == CNT_FULL;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// control squashing on bubbles and an optional two-entry skid buffer.
module pipe_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W  = XLEN,
    parameter int CTRL_W  = 4,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    cnt_e              state;
    cnt_e              next_state;
    logic              in_ready_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // in_ready_q is computed from next_state so upstream sees a clean register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CNT_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            in_ready_q <= !cnt_is_full(next_state);
        end
    end

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = CNT_EMPTY;
        end else begin
            unique case (state)
                CNT_EMPTY: begin
                    if (in_fire) begin
                        next_state   = CNT_ONE;
                        load_main_in = 1'b1;
                    end
                end
                CNT_ONE: begin
                    if (in_fire && (out_fire || !SKID_EN)) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        next_state = CNT_FULL;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        next_state = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (out_fire) begin
                        next_state     = CNT_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: next_state = CNT_EMPTY;
            endcase
        end
    end

    // Without the skid buffer in_ready must see out_ready combinationally
    always_comb begin
        out_valid = (state != CNT_EMPTY);
        in_ready  = SKID_EN ? in_ready_q : (out_ready || (state == CNT_EMPTY));
        out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    end

    // Data is only loaded on a transfer into main, so it persists across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    assign out_data = main_data;
    assign count    = state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: runs a skid and a non-skid instance side by side
// against a queue-based model, plus directed literal checks.
module tb_pipe_skid_reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [3:0]  s_out_ctrl, n_out_ctrl;
    logic [31:0] s_out_data, n_out_data;
    logic [1:0]  s_count, n_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    entry_t      q_s[$];
    entry_t      q_n[$];
    logic [31:0] last_s, last_n;
    bit          model_live = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(1'b1)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data), .count(s_count)
    );

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(1'b0)) dut_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_ctrl(n_out_ctrl), .out_data(n_out_data), .count(n_count)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge and stay stable until the next
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [31:0] d,
                                 input logic ordy, input logic fl, input logic r);
        @(posedge clk);
        #2;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
    endtask

    // Reference model: each instance is a bounded FIFO; out_data is the last head
    initial begin
        entry_t e;
        bit rdy_s, rdy_n;
        forever begin
            @(posedge clk);
            rdy_s = (q_s.size() < 2);
            rdy_n = out_ready || (q_n.size() == 0);
            e.ctrl = in_ctrl;
            e.data = in_data;
            if (rst) begin
                q_s.delete();
                q_n.delete();
                last_s     = '0;
                last_n     = '0;
                model_live = 1'b1;
            end else if (model_live) begin
                if (flush) begin
                    q_s.delete();
                    q_n.delete();
                end else begin
                    if (out_ready && q_s.size() > 0) void'(q_s.pop_front());
                    if (in_valid && rdy_s) q_s.push_back(e);
                    if (out_ready && q_n.size() > 0) void'(q_n.pop_front());
                    if (in_valid && rdy_n) q_n.push_back(e);
                end
                if (q_s.size() > 0) last_s = q_s[0].data;
                if (q_n.size() > 0) last_n = q_n[0].data;
            end
        end
    end

    // Compare both instances against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                checkOutput("s_out_valid", 64'(s_out_valid), 64'(q_s.size() > 0));
                checkOutput("s_out_ctrl", 64'(s_out_ctrl),
                            64'((q_s.size() > 0) ? q_s[0].ctrl : 4'h0));
                checkOutput("s_out_data", 64'(s_out_data), 64'(last_s));
                checkOutput("s_count", 64'(s_count), 64'(q_s.size()));
                checkOutput("s_in_ready", 64'(s_in_ready), 64'(q_s.size() < 2));
                checkOutput("n_out_valid", 64'(n_out_valid), 64'(q_n.size() > 0));
                checkOutput("n_out_ctrl", 64'(n_out_ctrl),
                            64'((q_n.size() > 0) ? q_n[0].ctrl : 4'h0));
                checkOutput("n_out_data", 64'(n_out_data), 64'(last_n));
                checkOutput("n_count", 64'(n_count), 64'(q_n.size()));
                checkOutput("n_in_ready", 64'(n_in_ready),
                            64'(out_ready || (q_n.size() == 0)));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = 32'h0000_0123;
        out_ready = 1'b0;

        // Reset held for two edges with a live input
        applyStimulus(1'b1, 4'hF, 32'h0000_0123, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("rst_s_out_valid", 64'(s_out_valid), 64'd0);
        checkOutput("rst_s_out_ctrl", 64'(s_out_ctrl), 64'd0);
        checkOutput("rst_s_out_data", 64'(s_out_data), 64'd0);
        checkOutput("rst_s_count", 64'(s_count), 64'd0);
        checkOutput("rst_s_in_ready", 64'(s_in_ready), 64'd1);
        checkOutput("rst_n_out_data", 64'(n_out_data), 64'd0);
        checkOutput("rst_n_count", 64'(n_count), 64'd0);

        // Streaming 1..4 with out_ready held high
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(i <= 4, 4'b0101, 32'(i), 1'b1, 1'b0, 1'b0);
            if (i >= 2) begin
                #1;
                checkOutput("stream_s_data", 64'(s_out_data), 64'(i - 1));
                checkOutput("stream_s_ctrl", 64'(s_out_ctrl), 64'h5);
                checkOutput("stream_s_count", 64'(s_count), 64'd1);
                checkOutput("stream_n_data", 64'(n_out_data), 64'(i - 1));
            end
        end
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("stream_end_valid", 64'(s_out_valid), 64'd0);
        checkOutput("stream_end_data", 64'(s_out_data), 64'd4);

        // Bubble squash after an all-ones control word
        applyStimulus(1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("bubble_ctrl_live", 64'(s_out_ctrl), 64'hF);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("bubble_ctrl_zero", 64'(s_out_ctrl), 64'h0);
        checkOutput("bubble_data_kept", 64'(s_out_data), 64'hDEAD_BEEF);
        checkOutput("bubble_n_ctrl_zero", 64'(n_out_ctrl), 64'h0);

        // Stall with two entries, then release
        applyStimulus(1'b1, 4'h3, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("stall_s_count1", 64'(s_count), 64'd1);
        checkOutput("stall_s_dataA", 64'(s_out_data), 64'hAAAA_0001);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'h0, 32'h0, k == 2, 1'b0, 1'b0);
            #1;
            checkOutput("stall_s_count2", 64'(s_count), 64'd2);
            checkOutput("stall_s_in_ready", 64'(s_in_ready), 64'd0);
            checkOutput("stall_s_dataA_hold", 64'(s_out_data), 64'hAAAA_0001);
            checkOutput("stall_n_count", 64'(n_count), 64'd1);
            checkOutput("stall_n_dataA", 64'(n_out_data), 64'hAAAA_0001);
        end
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("release_s_dataB", 64'(s_out_data), 64'hBBBB_0002);
        checkOutput("release_s_count", 64'(s_count), 64'd1);
        checkOutput("release_n_count", 64'(n_count), 64'd0);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("release_s_empty", 64'(s_count), 64'd0);

        // Flush while full, with a live input in the same cycle
        applyStimulus(1'b1, 4'h3, 32'h1111_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 32'h2222_0002, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h7, 32'hCCCC_0003, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("flush_pre_count", 64'(s_count), 64'd2);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("flush_s_count", 64'(s_count), 64'd0);
        checkOutput("flush_s_valid", 64'(s_out_valid), 64'd0);
        checkOutput("flush_s_ctrl", 64'(s_out_ctrl), 64'd0);
        checkOutput("flush_s_data_kept", 64'(s_out_data), 64'h1111_0001);
        checkOutput("flush_s_in_ready", 64'(s_in_ready), 64'd1);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("flush_no_C", 64'(s_out_valid), 64'd0);

        // Flush in ONE drops an accepted input
        applyStimulus(1'b1, 4'h3, 32'hEEEE_0004, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 32'hCCCC_0005, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("flush1_s_count", 64'(s_count), 64'd0);
        checkOutput("flush1_s_data", 64'(s_out_data), 64'hEEEE_0004);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("flush1_no_C", 64'(s_out_valid), 64'd0);

        // Non-skid mode with out_ready toggling 1,0,1 under a steady stream
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4'h9, 32'h0000_0100 + 32'(k), (k % 2) == 0, 1'b0, 1'b0);
        end

        // Randomised traffic, flushes and occasional resets
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom), $urandom,
                          $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 149) == 0);
        end
        repeat (4) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
